// File: rtl/flt_par_loader.sv
// Parameter-memory load sequencer: takes a load command, pulls words over a valid/ready stream,
// and issues one sequential write per word into the FLT parameter memory. It then verifies an XOR checksum.
module flt_par_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_WIDTH  = 32
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic                  Start_SI,
  input  logic [ADDR_WIDTH-1:0] StartAddr_DI,
  input  logic [ADDR_WIDTH:0]   Count_DI,
  input  logic [MEM_WIDTH-1:0]  ExpSum_DI,
  input  logic                  Abort_SI,
  input  logic                  WordVld_SI,
  input  logic [MEM_WIDTH-1:0]  Word_DI,
  output logic                  WordRdy_SO,
  output logic                  WrEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [MEM_WIDTH-1:0]  PAR_Out_DO,
  output logic                  Busy_SO,
  output logic                  Done_SO,
  output logic [1:0]            ErrCode_DO
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_RANGE   = 2'b01,
    ERR_CHKSUM  = 2'b10,
    ERR_ABORTED = 2'b11
  } err_e;

  state_e                state_q;
  logic                  rdy_q;
  logic                  busy_q;
  logic                  done_q;
  err_e                  err_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] addr_out_q;
  logic [MEM_WIDTH-1:0]  par_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [MEM_WIDTH-1:0]  sum_q;
  logic [MEM_WIDTH-1:0]  exp_q;

  // One extra bit so StartAddr+Count can reach past the top of memory without overflowing.
  logic [ADDR_WIDTH+1:0] end_addr;
  logic                  range_bad;
  logic                  xfer;

  assign end_addr  = {2'b00, StartAddr_DI} + {1'b0, Count_DI};
  assign range_bad = (Count_DI == '0) || (end_addr > (ADDR_WIDTH+2)'(DEPTH));
  assign xfer      = WordVld_SI & rdy_q;

  // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      wr_en_q     <= 1'b0;
      addr_out_q  <= '0;
      par_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      sum_q       <= '0;
      exp_q       <= '0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start_SI) begin
            if (range_bad) begin
              err_q   <= ERR_RANGE;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              addr_q      <= StartAddr_DI;
              remaining_q <= Count_DI;
              exp_q       <= ExpSum_DI;
              sum_q       <= '0;
              err_q       <= ERR_OK;
              rdy_q       <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Abort wins over a same-cycle transfer: the word is consumed but never written.
          if (Abort_SI) begin
            err_q   <= ERR_ABORTED;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (xfer) begin
            wr_en_q     <= 1'b1;
            addr_out_q  <= addr_q;
            par_q       <= Word_DI;
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
            sum_q       <= sum_q ^ Word_DI;
            if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
              rdy_q   <= 1'b0;
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          err_q   <= (sum_q == exp_q) ? ERR_OK : ERR_CHKSUM;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign WordRdy_SO = rdy_q;
  assign WrEn_SO    = wr_en_q;
  assign Addr_DO    = addr_out_q;
  assign PAR_Out_DO = par_q;
  assign Busy_SO    = busy_q;
  assign Done_SO    = done_q;
  assign ErrCode_DO = err_q;

endmodule
